// File: rtl/unit_ramp_driver_pkg.sv
// Shared defaults and state encoding for the unit ramp driver.
// The macro ROTATE_EN (see unit_ramp_driver.sv) selects wear-levelling rotation.
package unit_ramp_driver_pkg;

  localparam int N_UNITS_DEF     = 8;
  localparam int CNT_W_DEF       = 4;
  localparam int STEP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Width of a register that must hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unit_ramp_driver_thermo_decoder.sv
// Count to thermometer code, rotated left by rot. Inverse of a ones-counter:
// the ones-count of code always equals count (for count <= N_UNITS).
module unit_ramp_driver_thermo_decoder
  import unit_ramp_driver_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BASE_W  = idx_w(N_UNITS_DEF)
) (
  input  logic [CNT_W-1:0]   count,
  input  logic [BASE_W-1:0]  rot,
  output logic [N_UNITS-1:0] code
);

  logic [N_UNITS-1:0]   therm;
  logic [2*N_UNITS-1:0] dbl;

  for (genvar i = 0; i < N_UNITS; i++) begin : g_therm
    assign therm[i] = (count > CNT_W'(i));
  end

  // Rotate via a doubled vector: the upper half of the shifted copy is the rotation.
  assign dbl  = {therm, therm} << rot;
  assign code = dbl[2*N_UNITS-1:N_UNITS];

endmodule

// File: rtl/unit_ramp_driver.sv
// Soft ramp of the cool/heat unit bank: one unit on/off every STEP_CYCLES clocks.
// Optional macro ROTATE_EN rotates the enable pattern for wear levelling.
module unit_ramp_driver
  import unit_ramp_driver_pkg::*;
#(
  parameter int N_UNITS     = N_UNITS_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [CNT_W-1:0]   req_count,
  output logic               req_ready,
  output logic [N_UNITS-1:0] en,
  output logic [CNT_W-1:0]   active_count,
  output logic               busy,
  output logic               done
);

  localparam int TMR_W  = idx_w(STEP_CYCLES);
  localparam int BASE_W = idx_w(N_UNITS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_UNITS);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   target, target_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   req_clamp;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               done_nxt;
  logic [BASE_W-1:0]  base, base_nxt;
  logic [N_UNITS-1:0] code_nxt;

  assign req_clamp = (req_count > CNT_MAX) ? CNT_MAX : req_count;
  assign req_ready = (state == IDLE);
  assign busy      = (state == UP) || (state == DOWN);

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = active_count;
    timer_nxt  = timer;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          target_nxt = req_clamp;
          timer_nxt  = TMR_LOAD;
          if (req_clamp > active_count)      state_nxt = UP;
          else if (req_clamp < active_count) state_nxt = DOWN;
          else                               done_nxt  = 1'b1;
        end
      end
      UP, DOWN: begin
        if (timer == '0) begin
          cnt_nxt   = (state == UP) ? active_count + 1'b1 : active_count - 1'b1;
          timer_nxt = TMR_LOAD;
          if (cnt_nxt == target) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ROTATE_EN
  // Base advances each time the bank fully drains, so the next ramp starts on a new unit.
  always_comb begin
    base_nxt = base;
    if (state == DOWN && timer == '0 && active_count == CNT_W'(1))
      base_nxt = (base == BASE_W'(N_UNITS - 1)) ? '0 : base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) base <= '0;
    else       base <= base_nxt;
  end
`else
  assign base_nxt = '0;
  assign base     = '0;
`endif

  unit_ramp_driver_thermo_decoder #(
    .N_UNITS (N_UNITS),
    .CNT_W   (CNT_W),
    .BASE_W  (BASE_W)
  ) u_dec (
    .count (cnt_nxt),
    .rot   (base_nxt),
    .code  (code_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      target       <= '0;
      active_count <= '0;
      timer        <= '0;
      done         <= 1'b0;
      en           <= '0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      active_count <= cnt_nxt;
      timer        <= timer_nxt;
      done         <= done_nxt;
      en           <= code_nxt;
    end
  end

endmodule
